// File: rtl/genius_seq_player.sv
// Colour-sequence generator/player for the Genius game: grows a stored sequence by one
// pseudo-random colour per round and replays it on the colour-mux select. Optional macro GENIUS_SPEEDUP_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start/next
// S_APPEND | one cycle: store lfsr[1:0] at seq_len (unless full), idx <= 0
// S_ON     | colour mem[idx] lit, timer counts the on duration down
// S_OFF    | dark gap, timer counts OFF_CYCLES down, then next step or DONE
// S_DONE   | one-cycle done pulse
module genius_seq_player #(
    parameter int          MAX_LEN    = 32,
    parameter int          ON_CYCLES  = 4,
    parameter int          OFF_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           next,
    output logic [1:0]                     sel,
    output logic                           led_on,
    output logic                           busy,
    output logic                           done,
    output logic                           full,
    output logic [$clog2(MAX_LEN+1)-1:0]   seq_len
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int TMR_W = $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_lfsr;
    logic [1:0]         r_mem [MAX_LEN];
    logic [LEN_W-1:0]   r_seq_len;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic [TMR_W-1:0]   w_on_load;
    logic [1:0]         r_sel;
    logic               w_full;
    logic               w_last;
    logic               w_clr_len;
    logic               w_append;

    assign w_full = (r_seq_len == LEN_W'(MAX_LEN));
    assign w_last = (LEN_W'(r_idx) == (r_seq_len - LEN_W'(1)));

`ifdef GENIUS_SPEEDUP_EN
    logic [LEN_W-1:0]   w_dur_len;
    logic [LEN_W-1:0]   w_shrink;

    // In APPEND the timer is loaded before seq_len increments, so use the post-append length.
    assign w_dur_len = ((r_state == S_APPEND) && !w_full) ? (r_seq_len + LEN_W'(1)) : r_seq_len;
    assign w_shrink  = w_dur_len >> 2;
    assign w_on_load = (32'(w_shrink) >= 32'(ON_CYCLES)) ? '0
                     : TMR_W'(32'(ON_CYCLES) - 32'd1 - 32'(w_shrink));
`else
    assign w_on_load = TMR_W'(ON_CYCLES - 1);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmr_nxt   = r_tmr;
        w_clr_len   = 1'b0;
        w_append    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clr_len   = 1'b1;
                    w_state_nxt = S_APPEND;
                end else if (next) begin
                    w_state_nxt = S_APPEND;
                end
            end
            S_APPEND: begin
                w_append    = !w_full;
                w_idx_nxt   = '0;
                w_tmr_nxt   = w_on_load;
                w_state_nxt = S_ON;
            end
            S_ON: begin
                if (r_tmr == '0) begin
                    w_tmr_nxt   = TMR_W'(OFF_CYCLES - 1);
                    w_state_nxt = S_OFF;
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            S_OFF: begin
                if (r_tmr == '0) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_tmr_nxt   = w_on_load;
                        w_state_nxt = S_ON;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // Galois LFSR free-runs in every state so colour choice depends on command timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_len <= '0;
        end else if (w_clr_len) begin
            r_seq_len <= '0;
        end else if (w_append) begin
            r_seq_len <= r_seq_len + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_append) begin
            r_mem[r_seq_len[IDX_W-1:0]] <= r_lfsr[1:0];
        end
    end

    // sel reads memory directly while lit and keeps the last lit colour otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= 2'b00;
        end else if (r_state == S_ON) begin
            r_sel <= r_mem[r_idx];
        end
    end

    assign sel     = (r_state == S_ON) ? r_mem[r_idx] : r_sel;
    assign led_on  = (r_state == S_ON);
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign full    = w_full;
    assign seq_len = r_seq_len;

endmodule

// File: tb/tb_genius_seq_player.sv
// Scoreboard bench for genius_seq_player: command tasks push expected pulses/done records,
// a negedge monitor pops and compares them as the DUT plays.
module tb_genius_seq_player;

    localparam int MAX_LEN = 4;
    localparam int ON_C    = 4;
    localparam int OFF_C   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             next = 1'b0;
    logic [1:0]       sel;
    logic             led_on;
    logic             busy;
    logic             done;
    logic             full;
    logic [LEN_W-1:0] seq_len;

    genius_seq_player #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .next    (next),
        .sel     (sel),
        .led_on  (led_on),
        .busy    (busy),
        .done    (done),
        .full    (full),
        .seq_len (seq_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] col;
        int         w;
    } pulse_t;

    typedef struct {
        int on_cyc;
        int done_cyc;
        int len;
    } done_t;

    pulse_t exp_pulse[$];
    done_t  exp_done[$];

    int total = 0;
    int bad   = 0;
    int cyc;

    logic [15:0] m_lfsr;
    logic [1:0]  m_mem [MAX_LEN];
    int          m_len = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int on_dur(input int len);
        int d;
`ifdef GENIUS_SPEEDUP_EN
        d = ON_C - (len >> 2);
        if (d < 1) d = 1;
`else
        d = ON_C;
`endif
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            cyc    <= 0;
        end else begin
            m_lfsr <= lfsr_step(m_lfsr);
            cyc    <= cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a command for one cycle and push what the player must do in response.
    task automatic issue(input bit s, input bit n);
        logic [15:0] nxt_lfsr;
        logic [1:0]  col;
        int          span;
        done_t       d;
        @(posedge clk);
        #1;
        start = s;
        next  = n;
        nxt_lfsr = lfsr_step(m_lfsr);
        col      = nxt_lfsr[1:0];
        if (s) m_len = 0;
        if (m_len < MAX_LEN) begin
            m_mem[m_len] = col;
            m_len++;
        end
        span = 2;
        for (int i = 0; i < m_len; i++) begin
            exp_pulse.push_back('{col: m_mem[i], w: on_dur(m_len)});
            span += on_dur(m_len) + OFF_C;
        end
        d.on_cyc   = cyc + 2;
        d.done_cyc = cyc + span;
        d.len      = m_len;
        exp_done.push_back(d);
        @(posedge clk);
        #1;
        start = 1'b0;
        next  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        repeat (3) @(negedge clk);
        check("idle_after_done", 32'(busy), 0);
    endtask

    bit         in_pulse = 1'b0;
    bit         first    = 1'b1;
    bit         glitch   = 1'b0;
    logic [1:0] p_sel    = 2'b00;
    int         p_w      = 0;
    int         first_on = 0;

    always @(negedge clk) begin
        pulse_t e;
        done_t  d;
        if (!rst_n) begin
            in_pulse = 1'b0;
            first    = 1'b1;
        end else begin
            if (led_on === 1'b1) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    glitch   = 1'b0;
                    p_sel    = sel;
                    p_w      = 1;
                    if (first) begin
                        first_on = cyc;
                        first    = 1'b0;
                    end
                end else begin
                    p_w++;
                    if (sel !== p_sel) glitch = 1'b1;
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                if (exp_pulse.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_pulse.pop_front();
                    check("pulse_sel", 32'(p_sel), 32'(e.col));
                    check("pulse_width", 32'(p_w), 32'(e.w));
                    check("sel_hold_off", 32'(sel), 32'(p_sel));
                    check("sel_stable", 32'(glitch), 0);
                end
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    d = exp_done.pop_front();
                    check("first_on_cycle", 32'(first_on), 32'(d.on_cyc));
                    check("done_cycle", 32'(cyc), 32'(d.done_cyc));
                    check("seq_len", 32'(seq_len), 32'(d.len));
                    check("full", 32'(full), 32'(d.len == MAX_LEN));
                    check("busy_in_done", 32'(busy), 1);
                    check("led_off_in_done", 32'(led_on), 0);
                end
                first = 1'b1;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(sel), 0);
        check("rst_led_on", 32'(led_on), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_full", 32'(full), 0);
        check("rst_seq_len", 32'(seq_len), 0);
        rst_n = 1'b1;

        // First round exactly at cycle 10: lit 12-15, dark 16-17, done 18.
        while (cyc < 9) @(negedge clk);
        issue(1'b1, 1'b0);
        wait_done();

        // Grow to full, then one extra round that must not append.
        for (int r = 0; r < 3; r++) begin
            issue(1'b0, 1'b1);
            wait_done();
        end
        check("full_after_4", 32'(full), 1);
        issue(1'b0, 1'b1);
        wait_done();
        check("len_saturated", 32'(seq_len), MAX_LEN);

        // Commands while busy must be ignored.
        issue(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (1) @(posedge clk);
        #1 next = 1'b1;
        @(posedge clk);
        #1 next = 1'b0;
        wait_done();
        check("len_after_noise", 32'(seq_len), 1);
        issue(1'b0, 1'b1);
        wait_done();
        issue(1'b0, 1'b1);
        wait_done();

        // start and next together with three colours stored: start wins.
        issue(1'b1, 1'b1);
        wait_done();
        check("start_wins_len", 32'(seq_len), 1);

        // Reset in the middle of the first lit step of round 3.
        issue(1'b0, 1'b1);
        wait_done();
        issue(1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        check("pre_reset_led", 32'(led_on), 1);
        rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel), 0);
        check("arst_led_on", 32'(led_on), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_full", 32'(full), 0);
        check("arst_seq_len", 32'(seq_len), 0);
        exp_pulse.delete();
        exp_done.delete();
        m_len = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        while (cyc < 9) @(negedge clk);
        issue(1'b1, 1'b0);
        wait_done();

        repeat (2) @(negedge clk);
        check("pulses_left", 32'(exp_pulse.size()), 0);
        check("dones_left", 32'(exp_done.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
